// File: rtl/config_loader_if.sv
// -----------------------------------------------------------------------------
// config_loader_if -- serial bitstream input and tile config bus.
//
// Build option: CONFIG_LOADER_PARITY_EN adds parity_err.
//
// Signals
//   bit_in, bit_valid   serial bitstream from the source, MSB first
//   bit_ready           loader accepts a bit this cycle
//   config_data         32-bit write word broadcast to all tiles
//   config_en           one-hot write strobe, bit i = tile i
//   config_done         sticky, end-of-bitstream frame received
//   addr_err            one-cycle pulse, frame addressed a nonexistent tile
//   parity_err          one-cycle pulse, frame failed even parity (option only)
//
// Modports
//   master  the loader side (consumes bits, drives the config bus)
//   slave   the environment side (bitstream source and tiles)
// -----------------------------------------------------------------------------
interface config_loader_if #(
   parameter int NUM_TILES = 16
);
   logic                 bit_in;
   logic                 bit_valid;
   logic                 bit_ready;
   logic [31:0]          config_data;
   logic [NUM_TILES-1:0] config_en;
   logic                 config_done;
   logic                 addr_err;
`ifdef CONFIG_LOADER_PARITY_EN
   logic                 parity_err;
`endif

   modport master (
      input  bit_in, bit_valid,
      output bit_ready, config_data, config_en, config_done, addr_err
`ifdef CONFIG_LOADER_PARITY_EN
      , output parity_err
`endif
   );

   modport slave (
      output bit_in, bit_valid,
      input  bit_ready, config_data, config_en, config_done, addr_err
`ifdef CONFIG_LOADER_PARITY_EN
      , input parity_err
`endif
   );
endinterface

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader -- parses a serial configuration bitstream into tile writes.
//
// Frames are an 8-bit tile address followed by a 32-bit data word, MSB first.
// A valid address produces a one-cycle config_en strobe with the word on
// config_data; an out-of-range address pulses addr_err instead. Address 8'hFF
// ends the bitstream: the loader parks in DONE until reset.
//
// Build option: CONFIG_LOADER_PARITY_EN appends one even-parity bit over the
// 40 address+data bits; a mismatch pulses parity_err and drops the frame.
//
// Ports
//   clk     single clock, all state on posedge
//   reset   asynchronous, active-high
//   bus     config_loader_if.master (bitstream in, config bus out)
// -----------------------------------------------------------------------------
module config_loader #(
   parameter int NUM_TILES = 16
) (
   input  logic              clk,
   input  logic              reset,
   config_loader_if.master   bus
);

   localparam logic [2:0] ST_ADDR   = 3'd0;
   localparam logic [2:0] ST_DATA   = 3'd1;
   localparam logic [2:0] ST_WRITE  = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
`ifdef CONFIG_LOADER_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif

   logic [2:0]           state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [7:0]           addr_q, addr_d;
   logic [31:0]          data_q, data_d;
   logic [31:0]          cfg_data_q, cfg_data_d;
   logic [NUM_TILES-1:0] cfg_en_q, cfg_en_d;
   logic                 done_q, done_d;
   logic                 addr_err_q, addr_err_d;
   // Holds bit_ready low through reset and releases it on the first edge after.
   logic                 ready_en_q;
`ifdef CONFIG_LOADER_PARITY_EN
   logic                 parity_err_q, parity_err_d;
`endif

   logic                 accept;
   logic                 commit;
   logic [31:0]          commit_word;
   logic [NUM_TILES-1:0] tile_sel;

   // Address decode; an address >= NUM_TILES (including 8'hFF) matches nothing.
   generate
      for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_dec
         assign tile_sel[gi] = (addr_q == 8'(gi));
      end
   endgenerate

   always_comb begin
      bus.bit_ready = ready_en_q && ((state_q == ST_ADDR) || (state_q == ST_DATA)
`ifdef CONFIG_LOADER_PARITY_EN
                      || (state_q == ST_PARITY)
`endif
                      );
   end

   assign accept = bus.bit_valid && bus.bit_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      cfg_data_d  = cfg_data_q;
      cfg_en_d    = '0;
      done_d      = done_q;
      addr_err_d  = 1'b0;
      commit      = 1'b0;
      commit_word = data_q;
`ifdef CONFIG_LOADER_PARITY_EN
      parity_err_d = 1'b0;
`endif

      case (state_q)
         ST_ADDR: begin
            if (accept) begin
               addr_d = {addr_q[6:0], bus.bit_in};
               if (cnt_q == 5'd7) begin
                  cnt_d   = 5'd0;
                  state_d = ST_DATA;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         ST_DATA: begin
            if (accept) begin
               data_d = {data_q[30:0], bus.bit_in};
               if (cnt_q == 5'd31) begin
                  cnt_d = 5'd0;
`ifdef CONFIG_LOADER_PARITY_EN
                  state_d = ST_PARITY;
`else
                  commit      = 1'b1;
                  commit_word = data_d;
`endif
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
`ifdef CONFIG_LOADER_PARITY_EN
         ST_PARITY: begin
            if (accept) begin
               if (^{addr_q, data_q, bus.bit_in}) begin
                  // Bad frame: spend the write slot on the error pulse only.
                  parity_err_d = 1'b1;
                  state_d      = ST_WRITE;
               end else begin
                  commit = 1'b1;
               end
            end
         end
`endif
         ST_WRITE: state_d = ST_ADDR;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_ADDR;
      endcase

      // Outputs are registered, so they appear during the WRITE cycle itself.
      if (commit) begin
         if (addr_q == 8'hFF) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end else begin
            state_d = ST_WRITE;
            if (|tile_sel) begin
               cfg_en_d   = tile_sel;
               cfg_data_d = commit_word;
            end else begin
               addr_err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_ADDR;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         cfg_data_q <= '0;
         cfg_en_q   <= '0;
         done_q     <= 1'b0;
         addr_err_q <= 1'b0;
         ready_en_q <= 1'b0;
`ifdef CONFIG_LOADER_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cfg_data_q <= cfg_data_d;
         cfg_en_q   <= cfg_en_d;
         done_q     <= done_d;
         addr_err_q <= addr_err_d;
         ready_en_q <= 1'b1;
`ifdef CONFIG_LOADER_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.config_data = cfg_data_q;
   assign bus.config_en   = cfg_en_q;
   assign bus.config_done = done_q;
   assign bus.addr_err    = addr_err_q;
`ifdef CONFIG_LOADER_PARITY_EN
   assign bus.parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader -- directed bench for config_loader (NUM_TILES = 16).
// Parity frames are exercised when CONFIG_LOADER_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_config_loader;

   logic clk = 1'b0;
   logic reset;

   int n_cmp = 0;
   int n_mis = 0;
   int en_pulses = 0;
   int err_pulses = 0;

   config_loader_if #(.NUM_TILES(16)) bus ();

   config_loader #(.NUM_TILES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Count strobe cycles (values of the cycle that ends at this edge).
   always @(posedge clk) begin
      if (|bus.config_en) en_pulses++;
      if (bus.addr_err)   err_pulses++;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!bus.bit_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.bit_ready) check_val("ready_timeout", 64'(bus.bit_ready), 64'd1);
   endtask

   // Sends v[n-1] .. v[0]; returns at the negedge after the last transfer.
   task automatic send_bits(input logic [40:0] v, input int n, input bit gappy);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         if (gappy) begin
            bus.bit_valid = 1'b0;
            @(negedge clk);
         end
         bus.bit_in    = v[i];
         bus.bit_valid = 1'b1;
         wait_ready();
         @(posedge clk);
      end
      @(negedge clk);
      bus.bit_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input bit gappy,
                             input bit bad_par);
      logic [40:0] v;
      int n;
`ifdef CONFIG_LOADER_PARITY_EN
      v = {a, d, (^{a, d}) ^ bad_par};
      n = 41;
`else
      v = {bad_par & 1'b0, a, d};
      n = 40;
`endif
      send_bits(v, n, gappy);
   endtask

   initial begin
      int e0, r0, hi;
      reset         = 1'b1;
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_ready", 64'(bus.bit_ready), 64'd0);
      check_val("rst_en",    64'(bus.config_en), 64'd0);
      check_val("rst_data",  64'(bus.config_data), 64'd0);
      check_val("rst_done",  64'(bus.config_done), 64'd0);
      check_val("rst_aerr",  64'(bus.addr_err), 64'd0);
      #2 reset = 1'b0;
      #1 check_val("rel_ready_before_edge", 64'(bus.bit_ready), 64'd0);
      @(negedge clk);
      check_val("rel_ready_after_edge", 64'(bus.bit_ready), 64'd1);

      // Frame 03 / DEADBEEF continuous
      e0 = en_pulses;
      send_frame(8'h03, 32'hDEADBEEF, 1'b0, 1'b0);
      check_val("f1_en",    64'(bus.config_en), 64'h0008);
      check_val("f1_data",  64'(bus.config_data), 64'hDEADBEEF);
      check_val("f1_ready", 64'(bus.bit_ready), 64'd0);
      @(negedge clk);
      check_val("f1_en_next",    64'(bus.config_en), 64'd0);
      check_val("f1_ready_next", 64'(bus.bit_ready), 64'd1);
      check_val("f1_pulses",     64'(en_pulses - e0), 64'd1);

      // Same frame with gaps
      e0 = en_pulses;
      send_frame(8'h03, 32'hDEADBEEF, 1'b1, 1'b0);
      check_val("f2_en",   64'(bus.config_en), 64'h0008);
      check_val("f2_data", 64'(bus.config_data), 64'hDEADBEEF);
      @(negedge clk);
      check_val("f2_pulses", 64'(en_pulses - e0), 64'd1);

      // Nonexistent tile 0x20
      e0 = en_pulses; r0 = err_pulses;
      send_frame(8'h20, 32'h00000001, 1'b0, 1'b0);
      check_val("f3_en",   64'(bus.config_en), 64'd0);
      check_val("f3_aerr", 64'(bus.addr_err), 64'd1);
      check_val("f3_data", 64'(bus.config_data), 64'hDEADBEEF);
      @(negedge clk);
      check_val("f3_aerr_next", 64'(bus.addr_err), 64'd0);
      check_val("f3_en_pulses", 64'(en_pulses - e0), 64'd0);
      check_val("f3_err_pulses", 64'(err_pulses - r0), 64'd1);

      // Boundaries: last tile, first bad tile, last bad tile
      send_frame(8'h0F, 32'h000000A5, 1'b0, 1'b0);
      check_val("f4_en",   64'(bus.config_en), 64'h8000);
      check_val("f4_data", 64'(bus.config_data), 64'h000000A5);
      send_frame(8'h10, 32'h11111111, 1'b0, 1'b0);
      check_val("f5_aerr", 64'(bus.addr_err), 64'd1);
      check_val("f5_en",   64'(bus.config_en), 64'd0);
      send_frame(8'hFE, 32'h22222222, 1'b0, 1'b0);
      check_val("f6_aerr", 64'(bus.addr_err), 64'd1);
      check_val("f6_data", 64'(bus.config_data), 64'h000000A5);

      // Reset after 20 bits of a frame
      send_bits(41'({8'h07, 32'hFFFFFFFF} >> 20), 20, 1'b0);
      reset = 1'b1;
      #1 check_val("mid_rst_ready", 64'(bus.bit_ready), 64'd0);
      check_val("mid_rst_data", 64'(bus.config_data), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      e0 = en_pulses;
      send_frame(8'h00, 32'h12345678, 1'b0, 1'b0);
      check_val("f7_en",   64'(bus.config_en), 64'h0001);
      check_val("f7_data", 64'(bus.config_data), 64'h12345678);
      @(negedge clk);
      check_val("f7_pulses", 64'(en_pulses - e0), 64'd1);

      // End marker, then bits offered in DONE
      e0 = en_pulses;
      send_frame(8'hFF, 32'hA5A5A5A5, 1'b0, 1'b0);
      check_val("end_done",  64'(bus.config_done), 64'd1);
      check_val("end_ready", 64'(bus.bit_ready), 64'd0);
      check_val("end_en",    64'(bus.config_en), 64'd0);
      hi = 0;
      bus.bit_valid = 1'b1;
      for (int i = 0; i < 45; i++) begin
         bus.bit_in = i[0];
         @(negedge clk);
         if (bus.bit_ready) hi++;
      end
      bus.bit_valid = 1'b0;
      check_val("done_ready_cycles", 64'(hi), 64'd0);
      check_val("done_sticky",       64'(bus.config_done), 64'd1);
      check_val("done_no_strobe",    64'(en_pulses - e0), 64'd0);
      check_val("done_data",         64'(bus.config_data), 64'h12345678);

`ifdef CONFIG_LOADER_PARITY_EN
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      e0 = en_pulses;
      send_frame(8'h01, 32'h00000001, 1'b0, 1'b1);
      check_val("par_bad_err", 64'(bus.parity_err), 64'd1);
      check_val("par_bad_en",  64'(bus.config_en), 64'd0);
      @(negedge clk);
      check_val("par_bad_err_next", 64'(bus.parity_err), 64'd0);
      check_val("par_bad_pulses",   64'(en_pulses - e0), 64'd0);
      send_frame(8'h01, 32'h00000001, 1'b0, 1'b0);
      check_val("par_ok_en",  64'(bus.config_en), 64'h0002);
      check_val("par_ok_err", 64'(bus.parity_err), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   // Absolute bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter NUM_TILES, default 16, number of tile config ports driven (1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port bit_in  input  1  serial bitstream data, MSB first.
REQ-005 SHALL have port bit_valid  input  1  bit_in valid this cycle.
REQ-006 SHALL have port bit_ready  output  1  loader accepts a bit this cycle; a bit transfers when bit_valid && bit_ready.
REQ-007 SHALL have port config_data  output  32  write word broadcast to all tiles.
REQ-008 SHALL have port config_en  output  NUM_TILES  one-hot write strobe, bit i = tile i.
REQ-009 SHALL have port config_done  output  1  sticky; end-of-bitstream frame received.
REQ-010 SHALL have port addr_err  output  1  one-cycle pulse; frame addressed a nonexistent tile.

Function
REQ-011 SHALL parse frames of 8-bit tile address then 32-bit data word, MSB first, each bit one accepted transfer.
REQ-012 SHALL use FSM states ADDR (count 8 bits), DATA (count 32 bits), WRITE (one cycle), DONE.
REQ-013 SHALL go ADDR->DATA after the 8th accepted address bit, DATA->WRITE after the 32nd accepted data bit, WRITE->ADDR next cycle.
REQ-014 SHALL, in WRITE with address < NUM_TILES, drive config_data = assembled word and config_en[address] = 1 for exactly one cycle; all other config_en bits 0.
REQ-015 SHALL, in WRITE with NUM_TILES <= address < 8'hFF, assert no config_en bit and pulse addr_err for that cycle.
REQ-016 SHALL treat address 8'hFF as end marker: its 32 data bits are consumed and discarded, no strobe, FSM enters DONE and config_done sets.
REQ-017 SHALL hold config_data stable at the last written word outside WRITE cycles.
REQ-018 SHALL deassert bit_ready in WRITE and DONE; assert it in ADDR and DATA.
REQ-019 SHALL leave DONE only via reset; bits offered in DONE are not accepted.
REQ-020 SHALL not advance bit counters on cycles with bit_valid low (gaps of any length allowed).
REQ-021 SHALL give latency: config_en asserts the cycle after the 32nd data bit is accepted.

Reset
REQ-022 SHALL on reset assertion immediately force FSM to ADDR, counters to 0, config_data 0, config_en 0, config_done 0, addr_err 0.
REQ-023 SHALL discard any partial frame on reset mid-frame; next frame starts at address bit 7 after release.
REQ-024 SHALL hold bit_ready low while reset is asserted and raise it the first clock after release.

Configuration
REQ-025 SHALL, with macro CONFIG_LOADER_PARITY_EN defined, add state PARITY after DATA consuming one even-parity bit over the 40 address+data bits, and add output parity_err  1  one-cycle pulse.
REQ-026 SHALL, with CONFIG_LOADER_PARITY_EN defined and parity mismatch, suppress config_en (and end-marker action), pulse parity_err in place of WRITE, and return to ADDR.
REQ-027 SHALL, without CONFIG_LOADER_PARITY_EN, have no PARITY state, no parity_err port, and 40-bit frames.

Verification
REQ-028 Frame addr 8'h03, data 32'hDEADBEEF, bit_valid continuous -> one cycle later config_en = 16'h0008, config_data = 32'hDEADBEEF; bit_ready low that cycle.
REQ-029 Same frame with bit_valid low every other cycle -> identical single strobe, no duplicate or early strobe.
REQ-030 Frame addr 8'h20 (NUM_TILES=16), data 32'h1 -> config_en stays 0, addr_err pulses one cycle, config_data unchanged.
REQ-031 Frame addr 8'hFF then another valid frame -> config_done = 1, bit_ready = 0, no config_en afterwards.
REQ-032 Reset asserted after 20 bits of a frame, then frame addr 8'h00 data 32'h12345678 -> config_en = 16'h0001 with 32'h12345678 only.
REQ-033 CONFIG_LOADER_PARITY_EN defined, frame addr 8'h01 data 32'h00000001 with parity bit 1 (wrong) -> parity_err pulses, config_en stays 0; parity bit 0 -> config_en = 16'h0002.
